// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel window sequencer.
// Frame geometry defaults, FSM state encodings and counter sizing.
package sobel_pkg;

  localparam int unsigned DEF_LINE_WIDTH   = 640;
  localparam int unsigned DEF_FRAME_HEIGHT = 480;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FILL   = 2'd1;
  localparam state_t ST_ACTIVE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  function automatic int unsigned cntr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sobel_pos_cntr.sv
// Column/row position counter pair for a raster pixel stream.
// Holds the position of the next pixel; start loads the slot after (0,0).
module sobel_pos_cntr
  import sobel_pkg::*;
#(
  parameter int unsigned W = DEF_LINE_WIDTH,
  parameter int unsigned H = DEF_FRAME_HEIGHT,
  localparam int unsigned CW = cntr_w(W),
  localparam int unsigned RW = cntr_w(H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          start_i,
  input  logic          adv_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o
);

  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (start_i) begin
      // the restarting pixel itself sits at (0,0)
      col_d = CW'(1);
      row_d = '0;
    end else if (adv_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sobel 3x3 window sequencer: gates line-buffer shifts and
// qualifies complete neighbourhoods for the kernel stage.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned LINE_WIDTH   = DEF_LINE_WIDTH,
  parameter int unsigned FRAME_HEIGHT = DEF_FRAME_HEIGHT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pixel_valid,
  input  logic                            sof,
  output logic                            lb_shift_en,
  output logic                            win_valid,
  output logic [$clog2(FRAME_HEIGHT)-1:0] win_row,
  output logic [$clog2(LINE_WIDTH)-1:0]   win_col,
  output logic                            frame_done,
  output logic                            frame_err,
  output logic                            busy
);

  localparam int unsigned CW = cntr_w(LINE_WIDTH);
  localparam int unsigned RW = cntr_w(FRAME_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);

  state_t state_q, state_d;

  logic [CW-1:0] nxt_col;
  logic [RW-1:0] nxt_row;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;

  logic in_frame;
  logic restart;
  logic accept;
  logic at_eol;
  logic win_hit;
  logic last_hit;

  logic          win_valid_q;
  logic [RW-1:0] win_row_q;
  logic [CW-1:0] win_col_q;
  logic          done_q;
  logic          err_q;
  logic          busy_q;

  assign in_frame = (state_q == ST_FILL) || (state_q == ST_ACTIVE);
  assign restart  = pixel_valid && sof &&
                    (in_frame || (state_q == ST_IDLE));
  assign accept   = restart || (pixel_valid && in_frame);

  assign cur_col = restart ? '0 : nxt_col;
  assign cur_row = restart ? '0 : nxt_row;
  assign at_eol  = accept && (cur_col == COL_LAST);

  // ACTIVE implies cur_row >= 2, so only the column needs qualifying
  assign win_hit  = accept && !restart &&
                    (state_q == ST_ACTIVE) &&
                    (cur_col >= CW'(2));
  assign last_hit = at_eol && !restart &&
                    (state_q == ST_ACTIVE) &&
                    (cur_row == ROW_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (restart) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (restart) begin
          state_d = ST_FILL;
        end else if (at_eol && cur_row == RW'(1)) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (restart) begin
          state_d = ST_FILL;
        end else if (last_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  sobel_pos_cntr #(
    .W (LINE_WIDTH),
    .H (FRAME_HEIGHT)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (state_q == ST_DONE),
    .start_i (restart),
    .adv_i   (accept && !restart),
    .col_o   (nxt_col),
    .row_o   (nxt_row)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_valid_q <= win_hit;
      if (win_hit) begin
        win_row_q <= cur_row - 1'b1;
        win_col_q <= cur_col - 1'b1;
      end
      done_q      <= last_hit;
      err_q       <= pixel_valid && sof && in_frame;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign lb_shift_en = accept;
  assign win_valid   = win_valid_q;
  assign win_row     = win_row_q;
  assign win_col     = win_col_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 10x5 frame.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_sobel_window_ctrl;

  logic       clk;
  logic       rst;
  logic       pixel_valid;
  logic       sof;
  logic       lb_shift_en;
  logic       win_valid;
  logic [2:0] win_row;
  logic [3:0] win_col;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  int total;
  int bad;

  int cyc, wins, seq_base, seq_err;
  int first_win, fr, fc, lr, lc;
  int done_cnt, done_cyc, done_with_last;
  int err_cnt, err_cyc;
  logic shift_s, busy_s, winv_s;

  sobel_window_ctrl #(
    .LINE_WIDTH   (10),
    .FRAME_HEIGHT (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_valid (pixel_valid),
    .sof         (sof),
    .lb_shift_en (lb_shift_en),
    .win_valid   (win_valid),
    .win_row     (win_row),
    .win_col     (win_col),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic clr_stats();
    cyc = 0; wins = 0; seq_base = 0; seq_err = 0;
    first_win = -1; fr = -1; fc = -1; lr = -1; lc = -1;
    done_cnt = 0; done_cyc = -1; done_with_last = 0;
    err_cnt = 0; err_cyc = -1;
  endtask

  task automatic tick(input logic pv, input logic sf);
    int k;
    @(posedge clk);
    #1;
    pixel_valid = pv;
    sof = sf;
    @(negedge clk);
    shift_s = lb_shift_en;
    busy_s  = busy;
    winv_s  = win_valid;
    if (win_valid) begin
      if (wins == seq_base) begin
        first_win = cyc;
        fr = int'(win_row);
        fc = int'(win_col);
      end
      k = (wins - seq_base) % 24;
      if (int'(win_row) != 1 + k / 8 || int'(win_col) != 1 + k % 8)
        seq_err++;
      lr = int'(win_row);
      lc = int'(win_col);
      wins++;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (win_valid && win_row == 3'd3 && win_col == 4'd8)
        done_with_last++;
    end
    if (frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pixel_valid = 1'b0;
    sof = 1'b0;
    #3;
    total++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_pulses got=%b%b%b exp=000", win_valid, frame_done, frame_err);
    end
    total++;
    if (win_row !== 3'd0 || win_col !== 4'd0) begin
      bad++;
      $display("FAIL rst_rowcol got=%0d,%0d exp=0,0", win_row, win_col);
    end
    total++;
    if (busy !== 1'b0 || lb_shift_en !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy_shift got=%b%b exp=00", busy, lb_shift_en);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_no_sof();
    int shift_any, busy_any;
    clr_stats();
    shift_any = 0;
    busy_any = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b1, 1'b0);
      if (shift_s) shift_any++;
      if (busy_s) busy_any++;
    end
    tick(1'b0, 1'b0);
    total++;
    if (shift_any != 0) begin
      bad++;
      $display("FAIL nosof_shift got=%0d exp=0", shift_any);
    end
    total++;
    if (busy_any != 0) begin
      bad++;
      $display("FAIL nosof_busy got=%0d exp=0", busy_any);
    end
    total++;
    if (wins != 0) begin
      bad++;
      $display("FAIL nosof_wins got=%0d exp=0", wins);
    end
  endtask

  task automatic test_continuous();
    int shift_miss;
    clr_stats();
    shift_miss = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b1, i == 0);
      if (shift_s !== 1'b1) shift_miss++;
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    total++;
    if (wins != 24) begin
      bad++;
      $display("FAIL cont_wins got=%0d exp=24", wins);
    end
    total++;
    if (first_win != 23) begin
      bad++;
      $display("FAIL cont_first_cyc got=%0d exp=23", first_win);
    end
    total++;
    if (fr != 1 || fc != 1) begin
      bad++;
      $display("FAIL cont_first_ctr got=%0d,%0d exp=1,1", fr, fc);
    end
    total++;
    if (lr != 3 || lc != 8) begin
      bad++;
      $display("FAIL cont_last_ctr got=%0d,%0d exp=3,8", lr, lc);
    end
    total++;
    if (seq_err != 0) begin
      bad++;
      $display("FAIL cont_order got=%0d exp=0", seq_err);
    end
    total++;
    if (done_cnt != 1 || done_cyc != 50) begin
      bad++;
      $display("FAIL cont_done got=%0d@%0d exp=1@50", done_cnt, done_cyc);
    end
    total++;
    if (done_with_last != 1) begin
      bad++;
      $display("FAIL cont_done_last got=%0d exp=1", done_with_last);
    end
    total++;
    if (shift_miss != 0) begin
      bad++;
      $display("FAIL cont_shift got=%0d exp=0", shift_miss);
    end
    total++;
    if (busy_s !== 1'b0 || err_cnt != 0) begin
      bad++;
      $display("FAIL cont_end got=%b/%0d exp=0/0", busy_s, err_cnt);
    end
  endtask

  task automatic test_gapped();
    int shift_bad;
    logic pv;
    clr_stats();
    shift_bad = 0;
    for (int i = 0; i < 100; i++) begin
      pv = (i % 2 == 0);
      tick(pv, i == 0);
      if (shift_s !== pv) shift_bad++;
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    total++;
    if (wins != 24 || seq_err != 0) begin
      bad++;
      $display("FAIL gap_wins got=%0d/%0d exp=24/0", wins, seq_err);
    end
    total++;
    if (first_win != 45) begin
      bad++;
      $display("FAIL gap_first_cyc got=%0d exp=45", first_win);
    end
    total++;
    if (done_cnt != 1 || done_cyc != 99) begin
      bad++;
      $display("FAIL gap_done got=%0d@%0d exp=1@99", done_cnt, done_cyc);
    end
    total++;
    if (shift_bad != 0) begin
      bad++;
      $display("FAIL gap_shift got=%0d exp=0", shift_bad);
    end
  endtask

  task automatic test_mid_sof();
    logic busy35, win35;
    clr_stats();
    busy35 = 1'b0;
    win35 = 1'b1;
    for (int i = 0; i < 84; i++) begin
      tick(1'b1, i == 0 || i == 34);
      if (i == 34) seq_base = wins;
      if (i == 35) begin
        busy35 = busy_s;
        win35 = winv_s;
      end
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    total++;
    if (err_cnt != 1 || err_cyc != 35) begin
      bad++;
      $display("FAIL mid_err got=%0d@%0d exp=1@35", err_cnt, err_cyc);
    end
    total++;
    if (seq_base != 10) begin
      bad++;
      $display("FAIL mid_pre_wins got=%0d exp=10", seq_base);
    end
    total++;
    if (busy35 !== 1'b1 || win35 !== 1'b0) begin
      bad++;
      $display("FAIL mid_after_err got=%b%b exp=10", busy35, win35);
    end
    total++;
    if (first_win != 57 || fr != 1 || fc != 1) begin
      bad++;
      $display("FAIL mid_restart_win got=%0d(%0d,%0d) exp=57(1,1)", first_win, fr, fc);
    end
    total++;
    if (wins != 34 || seq_err != 0) begin
      bad++;
      $display("FAIL mid_wins got=%0d/%0d exp=34/0", wins, seq_err);
    end
    total++;
    if (done_cnt != 1 || done_cyc != 84) begin
      bad++;
      $display("FAIL mid_done got=%0d@%0d exp=1@84", done_cnt, done_cyc);
    end
  endtask

  task automatic test_async_reset();
    clr_stats();
    for (int i = 0; i < 26; i++) tick(1'b1, i == 0);
    total++;
    if (winv_s !== 1'b1 || busy_s !== 1'b1) begin
      bad++;
      $display("FAIL arst_pre got=%b%b exp=11", winv_s, busy_s);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (win_valid !== 1'b0 || busy !== 1'b0 || lb_shift_en !== 1'b0) begin
      bad++;
      $display("FAIL arst_flags got=%b%b%b exp=000", win_valid, busy, lb_shift_en);
    end
    total++;
    if (win_row !== 3'd0 || win_col !== 4'd0 || frame_done !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL arst_vals got=%0d,%0d,%b%b exp=0,0,00", win_row, win_col, frame_done, frame_err);
    end
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clr_stats();
    for (int i = 0; i < 50; i++) tick(1'b1, i == 0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    total++;
    if (wins != 24 || seq_err != 0 || done_cnt != 1) begin
      bad++;
      $display("FAIL arst_frame got=%0d/%0d/%0d exp=24/0/1", wins, seq_err, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic done_shift;
    clr_stats();
    done_shift = 1'b1;
    for (int i = 0; i < 50; i++) tick(1'b1, i == 0);
    tick(1'b1, 1'b1);
    done_shift = shift_s;
    for (int i = 0; i < 50; i++) tick(1'b1, i == 0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    total++;
    if (done_shift !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done_drop got=%b exp=0", done_shift);
    end
    total++;
    if (wins != 48 || seq_err != 0) begin
      bad++;
      $display("FAIL b2b_wins got=%0d/%0d exp=48/0", wins, seq_err);
    end
    total++;
    if (done_cnt != 2 || done_cyc != 101) begin
      bad++;
      $display("FAIL b2b_done got=%0d@%0d exp=2@101", done_cnt, done_cyc);
    end
    total++;
    if (err_cnt != 0) begin
      bad++;
      $display("FAIL b2b_err got=%0d exp=0", err_cnt);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    shift_s = 1'b0;
    busy_s = 1'b0;
    winv_s = 1'b0;
    clr_stats();
    test_reset();
    test_no_sof();
    test_continuous();
    test_gapped();
    test_mid_sof();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Sequencer for the Sobel 3x3 window datapath: tracks the row/column position of the incoming pixel stream, gates the shift enable of the two cascaded line-delay buffers, and flags when a full 3x3 neighbourhood is present. Sits between the pixel source and the line-buffer/window-register chain; its outputs qualify the Sobel kernel stage and mark frame completion and framing errors.

## Interface
- LINE_WIDTH, 640, pixels per line (>= 3)
- FRAME_HEIGHT, 480, lines per frame (>= 3)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- pixel_valid  in  1  input pixel present this cycle
- sof  in  1  start of frame; meaningful only with pixel_valid, marks pixel (0,0)
- lb_shift_en  out  1  shift enable to both line-delay buffers (their data_valid)
- win_valid  out  1  3x3 window centred on (win_row, win_col) is complete
- win_row  out  $clog2(FRAME_HEIGHT)  centre row of the current window
- win_col  out  $clog2(LINE_WIDTH)  centre column of the current window
- frame_done  out  1  one-cycle pulse after the last pixel of a frame
- frame_err  out  1  one-cycle pulse on sof received mid-frame
- busy  out  1  high while not in IDLE

## Operation
- Counters in_col (0..LINE_WIDTH-1), in_row (0..FRAME_HEIGHT-1) address the pixel accepted this cycle.
- States: IDLE, FILL, ACTIVE, DONE.
- IDLE: pixel_valid without sof dropped, lb_shift_en=0. pixel_valid&&sof: accept as (0,0), go FILL.
- FILL: in_row 0..1. Pixels accepted, no windows. Accepting (LINE_WIDTH-1, 1) -> ACTIVE.
- ACTIVE: in_row 2..FRAME_HEIGHT-1. Accepting pixel with in_col>=2 yields window centred (in_row-1, in_col-1). Accepting (LINE_WIDTH-1, FRAME_HEIGHT-1) -> DONE.
- DONE: one cycle; frame_done=1; -> IDLE. pixel_valid in DONE is dropped (sof included).
- lb_shift_en = pixel_valid && pixel accepted (combinational, same cycle as pixel).
- Column wrap: in_col==LINE_WIDTH-1 -> in_col=0, in_row+1. Row wrap handled by DONE transition only.
- sof with pixel_valid in FILL/ACTIVE: frame_err pulse, counters restart, pixel accepted as (0,0), state FILL. sof without pixel_valid ignored everywhere.
- Border pixels (row 0, row H-1, col 0, col W-1) never get a window; downstream zeroes them.
- No back-pressure: every accepted pixel advances counters exactly once.

## Timing
- Reset values: state IDLE, counters 0, lb_shift_en 0 (pixel_valid held low implied), win_valid 0, win_row 0, win_col 0, frame_done 0, frame_err 0, busy 0.
- win_valid/win_row/win_col registered: assert 1 cycle after the accepting pixel_valid edge; deasserted in any cycle whose prior cycle accepted no window pixel.
- frame_done asserts the cycle after the last pixel is accepted (coincident with the final win_valid? no: final window is (H-2, W-2), emitted the same cycle as frame_done).
- frame_err asserts 1 cycle after the offending sof.
- busy = (state != IDLE), registered.
- Async reset mid-frame: all outputs to reset values immediately; next frame needs sof.
- Windows per frame: (LINE_WIDTH-2)*(FRAME_HEIGHT-2).

## Structure
- Shared package sobel_pkg: state enum (IDLE/FILL/ACTIVE/DONE), default LINE_WIDTH/FRAME_HEIGHT constants, counter-width helper.
- One sub-module natural: sobel_pos_cntr (column/row counter pair with wrap and sync clear), reused by the output formatter.
- FSM and window-qualify registers in the top module.

## Test plan
- W=10,H=5, continuous pixel_valid from sof -> exactly 24 win_valid pulses; first centre (1,1) one cycle after pixel (2,2) (cycle 23 after sof); last (3,8); frame_done with the last.
- Same frame, pixel_valid toggled 1-0 -> same 24 windows in identical order, counters hold on gaps, lb_shift_en only on accepted cycles.
- pixel_valid without sof from reset -> lb_shift_en never asserts, busy=0, no windows.
- sof again at pixel (4,3) -> frame_err pulse next cycle, state FILL, next window centre (1,1) after 22 more pixels.
- rst low mid-ACTIVE -> all outputs 0 asynchronously; after release, a full frame with sof yields 24 windows.
- Back-to-back frames, sof on the cycle after DONE -> both frames complete, two frame_done pulses, 48 windows.
